// File: rtl/execute_stage_pkg.sv
// Shared Y86-64 encodings for the execute stage: instruction, ALU, condition and status codes.
package execute_stage_pkg;

    localparam int NIBBLE = 4;
    localparam int D_WORD = 64;

    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_XOR = 4'h3
    } alufun_e;

    typedef enum logic [3:0] {
        C_YES = 4'h0,
        C_LE  = 4'h1,
        C_L   = 4'h2,
        C_E   = 4'h3,
        C_NE  = 4'h4,
        C_GE  = 4'h5,
        C_G   = 4'h6
    } cond_e;

    typedef enum logic [3:0] {
        S_AOK = 4'h1,
        S_HLT = 4'h2,
        S_ADR = 4'h3,
        S_INS = 4'h4
    } stat_e;

    localparam logic [3:0] RNONE = 4'hF;

    function automatic logic stat_is_exc(input logic [3:0] stat);
        return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode->execute register fields in, forwarding and memory-stage register fields out.
interface execute_stage_if #(
    parameter int WIDTH = 64
);
    logic [3:0]       E_stat_i;
    logic [3:0]       E_icode_i;
    logic [3:0]       E_ifun_i;
    logic [WIDTH-1:0] E_valC_i;
    logic [WIDTH-1:0] E_valA_i;
    logic [WIDTH-1:0] E_valB_i;
    logic [3:0]       E_dstE_i;
    logic [3:0]       E_dstM_i;
    logic [3:0]       m_stat_i;
    logic [3:0]       W_stat_i;
    logic             M_bubble_i;

    logic [WIDTH-1:0] e_valE_o;
    logic [3:0]       e_dstE_o;
    logic             e_Cnd_o;
    logic [3:0]       M_stat_o;
    logic [3:0]       M_icode_o;
    logic             M_Cnd_o;
    logic [WIDTH-1:0] M_valE_o;
    logic [WIDTH-1:0] M_valA_o;
    logic [3:0]       M_dstE_o;
    logic [3:0]       M_dstM_o;

    modport master (
        output E_stat_i, E_icode_i, E_ifun_i, E_valC_i, E_valA_i, E_valB_i,
               E_dstE_i, E_dstM_i, m_stat_i, W_stat_i, M_bubble_i,
        input  e_valE_o, e_dstE_o, e_Cnd_o, M_stat_o, M_icode_o, M_Cnd_o,
               M_valE_o, M_valA_o, M_dstE_o, M_dstM_o
    );

    modport slave (
        input  E_stat_i, E_icode_i, E_ifun_i, E_valC_i, E_valA_i, E_valB_i,
               E_dstE_i, E_dstM_i, m_stat_i, W_stat_i, M_bubble_i,
        output e_valE_o, e_dstE_o, e_Cnd_o, M_stat_o, M_icode_o, M_Cnd_o,
               M_valE_o, M_valA_o, M_dstE_o, M_dstM_o
    );

endinterface

// File: rtl/execute_stage_alu.sv
// Combinational Y86-64 ALU: result plus the zero/sign/overflow flags it would set.
module execute_stage_alu
    import execute_stage_pkg::*;
#(
    parameter int WIDTH = D_WORD
) (
    input  logic [WIDTH-1:0] alu_a_i,
    input  logic [WIDTH-1:0] alu_b_i,
    input  logic [3:0]       alu_fun_i,
    output logic [WIDTH-1:0] val_e_o,
    output logic             zf_o,
    output logic             sf_o,
    output logic             of_o
);

    logic sign_a;
    logic sign_b;

    assign sign_a = alu_a_i[WIDTH-1];
    assign sign_b = alu_b_i[WIDTH-1];

    always_comb begin
        val_e_o = '0;
        of_o    = 1'b0;
        case (alu_fun_i)
            ALU_ADD: begin
                val_e_o = alu_b_i + alu_a_i;
                of_o    = (sign_a == sign_b) && (val_e_o[WIDTH-1] != sign_a);
            end
            ALU_SUB: begin
                val_e_o = alu_b_i - alu_a_i;
                of_o    = (sign_a != sign_b) && (val_e_o[WIDTH-1] != sign_b);
            end
            ALU_AND: val_e_o = alu_b_i & alu_a_i;
            ALU_XOR: val_e_o = alu_b_i ^ alu_a_i;
            // Unknown ops yield zero so the flags look like a clean zero result.
            default: begin
                val_e_o = '0;
                of_o    = 1'b0;
            end
        endcase
        zf_o = (val_e_o == '0);
        sf_o = val_e_o[WIDTH-1];
    end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand select, ALU, condition codes, Cnd and the M pipeline register.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int WIDTH = D_WORD
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    execute_stage_if.slave  ex
);

    localparam logic [WIDTH-1:0] EIGHT = WIDTH'(8);

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_fun;
    logic [WIDTH-1:0] val_e;
    logic             alu_zf;
    logic             alu_sf;
    logic             alu_of;
    logic             set_cc;
    logic             cnd;
    logic [3:0]       dst_e;

    logic cc_zf_q, cc_zf_d;
    logic cc_sf_q, cc_sf_d;
    logic cc_of_q, cc_of_d;

    logic [3:0]       mr_stat_q,  mr_stat_d;
    logic [3:0]       mr_icode_q, mr_icode_d;
    logic             mr_cnd_q,   mr_cnd_d;
    logic [WIDTH-1:0] mr_val_e_q, mr_val_e_d;
    logic [WIDTH-1:0] mr_val_a_q, mr_val_a_d;
    logic [3:0]       mr_dst_e_q, mr_dst_e_d;
    logic [3:0]       mr_dst_m_q, mr_dst_m_d;

    always_comb begin
        alu_a = '0;
        case (ex.E_icode_i)
            I_RRMOVQ, I_OPQ:             alu_a = ex.E_valA_i;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = ex.E_valC_i;
            I_CALL, I_PUSHQ:             alu_a = -EIGHT;
            I_RET, I_POPQ:               alu_a = EIGHT;
            default:                     alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (ex.E_icode_i)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b = ex.E_valB_i;
            default: alu_b = '0;
        endcase
    end

    assign alu_fun = (ex.E_icode_i == I_OPQ) ? ex.E_ifun_i : ALU_ADD;

    execute_stage_alu #(.WIDTH(WIDTH)) u_alu (
        .alu_a_i   (alu_a),
        .alu_b_i   (alu_b),
        .alu_fun_i (alu_fun),
        .val_e_o   (val_e),
        .zf_o      (alu_zf),
        .sf_o      (alu_sf),
        .of_o      (alu_of)
    );

    // A faulting instruction further down the pipe must not see CC change behind it.
    assign set_cc = (ex.E_icode_i == I_OPQ) && !stat_is_exc(ex.m_stat_i)
                    && !stat_is_exc(ex.W_stat_i);

    always_comb begin
        cc_zf_d = cc_zf_q;
        cc_sf_d = cc_sf_q;
        cc_of_d = cc_of_q;
        if (set_cc) begin
            cc_zf_d = alu_zf;
            cc_sf_d = alu_sf;
            cc_of_d = alu_of;
        end
    end

    always_comb begin
        cnd = 1'b0;
        case (ex.E_ifun_i)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = (cc_sf_q ^ cc_of_q) | cc_zf_q;
            C_L:     cnd = cc_sf_q ^ cc_of_q;
            C_E:     cnd = cc_zf_q;
            C_NE:    cnd = ~cc_zf_q;
            C_GE:    cnd = ~(cc_sf_q ^ cc_of_q);
            C_G:     cnd = ~(cc_sf_q ^ cc_of_q) & ~cc_zf_q;
            default: cnd = 1'b0;
        endcase
    end

    assign dst_e = ((ex.E_icode_i == I_RRMOVQ) && !cnd) ? RNONE : ex.E_dstE_i;

    always_comb begin
        mr_stat_d  = ex.E_stat_i;
        mr_icode_d = ex.E_icode_i;
        mr_cnd_d   = cnd;
        mr_val_e_d = val_e;
        mr_val_a_d = ex.E_valA_i;
        mr_dst_e_d = dst_e;
        mr_dst_m_d = ex.E_dstM_i;
        if (ex.M_bubble_i) begin
            mr_stat_d  = S_AOK;
            mr_icode_d = I_NOP;
            mr_cnd_d   = 1'b0;
            mr_val_e_d = '0;
            mr_val_a_d = '0;
            mr_dst_e_d = RNONE;
            mr_dst_m_d = RNONE;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cc_zf_q <= 1'b1;
            cc_sf_q <= 1'b0;
            cc_of_q <= 1'b0;
        end else begin
            cc_zf_q <= cc_zf_d;
            cc_sf_q <= cc_sf_d;
            cc_of_q <= cc_of_d;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mr_stat_q  <= S_AOK;
            mr_icode_q <= I_NOP;
            mr_cnd_q   <= 1'b0;
            mr_val_e_q <= '0;
            mr_val_a_q <= '0;
            mr_dst_e_q <= RNONE;
            mr_dst_m_q <= RNONE;
        end else begin
            mr_stat_q  <= mr_stat_d;
            mr_icode_q <= mr_icode_d;
            mr_cnd_q   <= mr_cnd_d;
            mr_val_e_q <= mr_val_e_d;
            mr_val_a_q <= mr_val_a_d;
            mr_dst_e_q <= mr_dst_e_d;
            mr_dst_m_q <= mr_dst_m_d;
        end
    end

    assign ex.e_valE_o  = val_e;
    assign ex.e_dstE_o  = dst_e;
    assign ex.e_Cnd_o   = cnd;
    assign ex.M_stat_o  = mr_stat_q;
    assign ex.M_icode_o = mr_icode_q;
    assign ex.M_Cnd_o   = mr_cnd_q;
    assign ex.M_valE_o  = mr_val_e_q;
    assign ex.M_valA_o  = mr_val_a_q;
    assign ex.M_dstE_o  = mr_dst_e_q;
    assign ex.M_dstM_o  = mr_dst_m_q;

endmodule
